main_control_fsm: RTL and testbench
===================================

Name: main_control_fsm

Overview:
- Multi-cycle main control unit for the RISC CPU. It decodes the instruction opcode, sequences fetch, decode, execute, memory and writeback, and drives datapath enables.
- It is the producer of the 3-bit aluop consumed by the ALU control decoder; the encodings below must match that decoder bit-for-bit.
- Sits between the instruction register (opcode) and the datapath and memory port.

Parameters:
- OP_W, 6, opcode width.
- ST_W, 4, state register width (also width of state_out).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- aluop  out  3  110 R-type; 000 lw/sw/addi/PC-increment; 010 andi; 011 ori; 101 slti; 001 beq/bne.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch).
- branch_ne  out  1  condition polarity for pc_write_cond: 0 beq, 1 bne.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- iord  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- trap  out  1  illegal opcode flag (see Optional Feature).
- state_out  out  ST_W  current state, for debug.

Behaviour:
- Outputs are combinational from state, gated by mem_ready where noted. Every output not listed for a state is 0.
- Reset: asynchronous. State goes to IDLE, all outputs 0. Reset mid-instruction abandons it with no partial writes after reset asserts.
- IDLE: no outputs asserted. Next state FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=000.
  - ir_write=mem_ready, pc_write=mem_ready, pc_source=00.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, aluop=000 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC.
  - 100011 or 101011 -> MEM_ADDR.
  - 001000, 001100, 001101, 001010 -> I_EXEC.
  - 000100 or 000101 -> BRANCH.
  - 000010 -> JUMP.
  - any other opcode -> ILLEGAL.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluop=110. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. aluop is 000 (addi), 010 (andi), 011 (ori) or 101 (slti), from the opcode latched at DECODE. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=000. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Hold while !mem_ready; go to MEM_WB when mem_ready.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold while !mem_ready; go to FETCH when mem_ready.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=001, pc_write_cond=1, pc_source=01, branch_ne=opcode[0]. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- Opcode latch: opcode is captured into an internal register on DECODE exit. Later states use the latched copy; the opcode input may change after DECODE.
- ILLEGAL: behaviour depends on the Optional Feature.
- Cycle counts with mem_ready tied to 1:
  - R-type, I-type ALU and sw: 4 cycles.
  - lw: 5 cycles.
  - beq/bne and j: 3 cycles.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Unused state encodings go to IDLE on the next clock.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: ILLEGAL asserts trap=1 with all other outputs 0, and holds until reset. No PC update occurs.
- Undefined: ILLEGAL is a 1-cycle no-op. trap stays 0 permanently, and the next state is FETCH.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> all outputs 0 during reset; state_out IDLE, then FETCH with mem_read=1, ir_write=1, pc_write=1, aluop=000.
- opcode=000000, mem_ready=1 -> FETCH, DECODE, R_EXEC (aluop=110, alu_src_a=1, alu_src_b=00), R_WB (reg_write=1, reg_dst=1), FETCH. Total 4 cycles.
- opcode=100011, mem_ready low for 2 cycles in MEM_READ -> MEM_READ held 3 cycles with mem_read=1, iord=1; then MEM_WB with mem_to_reg=1, reg_write=1. Total 7 cycles.
- opcode=001101, then 001010 -> I_EXEC aluop=011, then aluop=101; alu_src_b=10 both times; I_WB reg_dst=0. Also: opcode changed to 000000 during I_EXEC -> aluop unchanged (latched value used).
- opcode=000101 -> BRANCH with aluop=001, pc_write_cond=1, branch_ne=1, pc_source=01. opcode=000010 -> JUMP with pc_write=1, pc_source=10.
- opcode=111111 -> with ILLEGAL_TRAP_EN: trap=1 held for 10 cycles, no pc_write, cleared by reset. Without it: one ILLEGAL cycle, then FETCH, trap=0 throughout.

Source files
------------

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle main control FSM (fetch/decode/execute/memory/writeback) driving datapath enables.
// Optional feature macro ILLEGAL_TRAP_EN: when defined, an illegal opcode raises trap and holds until reset.
module main_control_fsm #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic [2:0]      aluop,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            branch_ne,
    output logic [1:0]      pc_source,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            trap,
    output logic [ST_W-1:0] state_out
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] R_EXEC    = 4'd3;
    localparam logic [3:0] R_WB      = 4'd4;
    localparam logic [3:0] I_EXEC    = 4'd5;
    localparam logic [3:0] I_WB      = 4'd6;
    localparam logic [3:0] MEM_ADDR  = 4'd7;
    localparam logic [3:0] MEM_READ  = 4'd8;
    localparam logic [3:0] MEM_WB    = 4'd9;
    localparam logic [3:0] MEM_WRITE = 4'd10;
    localparam logic [3:0] BRANCH    = 4'd11;
    localparam logic [3:0] JUMP      = 4'd12;
    localparam logic [3:0] ILLEGAL   = 4'd13;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

`ifdef ILLEGAL_TRAP_EN
    localparam logic       TRAP_ON     = 1'b1;
    localparam logic [3:0] ILLEGAL_NXT = ILLEGAL;
`else
    localparam logic       TRAP_ON     = 1'b0;
    localparam logic [3:0] ILLEGAL_NXT = FETCH;
`endif

    logic [3:0]      state, state_nxt;
    logic [OP_W-1:0] op_q;
    logic [2:0]      imm_aluop;

    assign state_out = ST_W'(state);
    assign imm_aluop = (op_q == OP_ANDI) ? 3'b010 :
                       (op_q == OP_ORI)  ? 3'b011 :
                       (op_q == OP_SLTI) ? 3'b101 : 3'b000;

    // State register and opcode latch; the opcode is captured as DECODE is left
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE)
                op_q <= opcode;
        end
    end

    // Next-state sequencing; DECODE dispatches on the live opcode
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:      state_nxt = FETCH;
            FETCH:     state_nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == OP_R)
                    state_nxt = R_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_nxt = MEM_ADDR;
                else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_SLTI)
                    state_nxt = I_EXEC;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_nxt = BRANCH;
                else if (opcode == OP_J)
                    state_nxt = JUMP;
                else
                    state_nxt = ILLEGAL;
            end
            R_EXEC:    state_nxt = R_WB;
            R_WB:      state_nxt = FETCH;
            I_EXEC:    state_nxt = I_WB;
            I_WB:      state_nxt = FETCH;
            MEM_ADDR:  state_nxt = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_nxt = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    state_nxt = FETCH;
            MEM_WRITE: state_nxt = mem_ready ? FETCH : MEM_WRITE;
            BRANCH:    state_nxt = FETCH;
            JUMP:      state_nxt = FETCH;
            ILLEGAL:   state_nxt = ILLEGAL_NXT;
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath controls decoded from the current state, FETCH strobes gated by mem_ready
    always_comb begin
        aluop         = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        trap          = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:    alu_src_b = 2'b11;
            R_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 3'b110;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluop     = imm_aluop;
            end
            I_WB:      reg_write = 1'b1;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = op_q[0];
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            ILLEGAL:   trap = TRAP_ON;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: randomized instruction stream checked against a per-instruction cycle-list model.
module tb_main_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic [2:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, trap;
    logic [3:0] state_out;

    main_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .trap(trap), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic        mr;
        logic [18:0] e;
    } cyc_t;

    cyc_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_cyc = 0;

    logic [18:0] act;
    assign act = {aluop, alu_src_a, alu_src_b, pc_write, pc_write_cond, branch_ne, pc_source,
                  iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, trap};

    // Output vector in the same field order as act
    function automatic logic [18:0] o(input logic [2:0] alu, input logic a, input logic [1:0] b,
                                      input logic pcw, input logic pcwc, input logic bne,
                                      input logic [1:0] ps, input logic io, input logic mrd,
                                      input logic mwr, input logic irw, input logic rw,
                                      input logic rd, input logic m2r, input logic tr);
        return {alu, a, b, pcw, pcwc, bne, ps, io, mrd, mwr, irw, rw, rd, m2r, tr};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n_cyc, got, exp);
        end
    endtask

    function automatic void pushc(input logic [18:0] e);
        q.push_back({6'($urandom), 1'($urandom), e});
    endfunction
    function automatic void pushm(input logic mr, input logic [18:0] e);
        q.push_back({6'($urandom), mr, e});
    endfunction
    function automatic void pushd(input logic [5:0] op, input logic [18:0] e);
        q.push_back({op, 1'($urandom), e});
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h04, 6'h05, 6'h02};
    endfunction

    // Expected cycle list of one instruction; fw/mw are wait cycles in FETCH and the memory state
    function automatic void build(input logic [5:0] op, input int fw, input int mw);
        logic [2:0] ia;
        repeat (fw) pushm(1'b0, o(3'b000, 0, 2'b01, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        pushm(1'b1, o(3'b000, 0, 2'b01, 1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0));
        pushd(op, o(3'b000, 0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        ia = (op == 6'h0c) ? 3'b010 : (op == 6'h0d) ? 3'b011 : (op == 6'h0a) ? 3'b101 : 3'b000;
        if (op == 6'h00) begin
            pushc(o(3'b110, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
            pushc(o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
        end else if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0a}) begin
            pushc(o(ia, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
            pushc(o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
        end else if (op == 6'h23 || op == 6'h2b) begin
            pushc(o(3'b000, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
            if (op == 6'h23) begin
                repeat (mw) pushm(1'b0, o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0));
                pushm(1'b1, o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0));
                pushc(o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0));
            end else begin
                repeat (mw) pushm(1'b0, o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0));
                pushm(1'b1, o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0));
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            pushc(o(3'b001, 1, 2'b00, 0, 1, op[0], 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
        end else if (op == 6'h02) begin
            pushc(o(3'b000, 0, 2'b00, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
        end else begin
`ifdef ILLEGAL_TRAP_EN
            repeat (10) pushc(o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
`else
            pushc(o(3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        end
    endfunction

    task automatic step();
        cyc_t r;
        r = q.pop_front();
        @(negedge clk);
        opcode = r.op;
        mem_ready = r.mr;
        n_cyc++;
        #1;
        check("outputs", {13'b0, act}, {13'b0, r.e});
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("reset_outputs", {13'b0, act}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_outputs", {13'b0, act}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_outputs", {13'b0, act}, 32'h0);
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h04, 6'h05, 6'h02};
        do_reset();
        build(6'h00, 0, 0);
        check("len_rtype", q.size(), 4);
        repeat (3) step();
        check("r_exec", {26'b0, aluop, alu_src_a, alu_src_b}, 32'b110_1_00);
        step();
        check("r_wb", {29'b0, reg_write, reg_dst, mem_to_reg}, 32'b110);
        build(6'h23, 0, 0);
        check("len_lw", q.size(), 5);
        drain();
        build(6'h23, 0, 2);
        check("len_lw_wait", q.size(), 7);
        drain();
        build(6'h0d, 0, 0);
        repeat (3) step();
        check("ori_aluop", {29'b0, aluop}, 32'b011);
        drain();
        build(6'h0a, 0, 0);
        check("len_itype", q.size(), 4);
        repeat (3) step();
        check("slti_aluop", {29'b0, aluop}, 32'b101);
        drain();
        build(6'h05, 0, 0);
        check("len_branch", q.size(), 3);
        drain();
        check("bne", {26'b0, aluop, pc_write_cond, branch_ne, pc_source}, 32'b001_1_1_01);
        build(6'h02, 0, 0);
        check("len_jump", q.size(), 3);
        drain();
        check("jump", {29'b0, pc_write, pc_source}, 32'b1_10);
        build(6'h2b, 1, 1);
        check("len_sw_wait", q.size(), 6);
        drain();
        build(6'h3f, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        check("len_illegal", q.size(), 12);
        drain();
        do_reset();
`else
        check("len_illegal", q.size(), 3);
        drain();
`endif
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            build(op, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(1, q.size() - 1)) step();
                q.delete();
                do_reset();
            end else begin
                drain();
`ifdef ILLEGAL_TRAP_EN
                if (!legal(op)) do_reset();
`endif
            end
        end
        build(6'h00, 0, 0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
